// File: rtl/finger_round_engine.sv
// Round engine for the Finger Dancer core: draws a random target pattern, waits
// for the synchronised switches to match it within a tick window, and keeps score.
module finger_round_engine #(
    parameter int          N      = 4,
    parameter int          ROUNDS = 10,
    parameter int          WINDOW = 8,
    parameter logic [15:0] SEED   = 16'hACE1,
    localparam int         CW     = $clog2(ROUNDS + 1)
) (
    input  logic          board_clk,
    input  logic          rst_btn,
    input  logic          tick,
    input  logic          start,
    input  logic [N-1:0]  sw,
    output logic [N-1:0]  pattern,
    output logic          game,
    output logic [CW-1:0] count,
    output logic [CW-1:0] score,
    output logic          roundres,
    output logic          round_valid,
    output logic          done
);

    localparam int          WW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_WAIT,
        S_JUDGE,
        S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [N-1:0]  pattern_q, pattern_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] score_q, score_d;
    logic          roundres_q, roundres_d;
    logic          round_valid_q, round_valid_d;
    logic          done_q, done_d;
    logic          game_q, game_d;
    logic          hit_q, hit_d;
    logic [WW-1:0] win_q, win_d;
    logic [N-1:0]  sw_meta_q, sw_meta_d;
    logic [N-1:0]  sw_s_q, sw_s_d;

    logic [15:0]   lfsr_next;
    logic [N-1:0]  candidate;

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    assign candidate = lfsr_next[N-1:0];

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        pattern_d     = pattern_q;
        count_d       = count_q;
        score_d       = score_q;
        roundres_d    = roundres_q;
        round_valid_d = 1'b0;
        hit_d         = hit_q;
        win_d         = win_q;
        sw_meta_d     = sw;
        sw_s_d        = sw_meta_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d    = S_SHOW;
                    count_d    = '0;
                    score_d    = '0;
                    roundres_d = 1'b0;
                end
            end
            S_SHOW: begin
                lfsr_d = lfsr_next;
                // A repeat of the last target is rejected so stale switches cannot score instantly
                if (candidate != '0 && candidate != pattern_q) begin
                    pattern_d = candidate;
                    win_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sw_s_q == pattern_q) begin
                    hit_d   = 1'b1;
                    state_d = S_JUDGE;
                end else if (tick) begin
                    if (win_q == WIN_LAST) begin
                        hit_d   = 1'b0;
                        state_d = S_JUDGE;
                    end else begin
                        win_d = win_q + WW'(1);
                    end
                end
            end
            S_JUDGE: begin
                roundres_d    = hit_q;
                round_valid_d = 1'b1;
                count_d       = count_q + CW'(1);
                score_d       = score_q + CW'(hit_q);
                state_d       = (count_d == CW'(ROUNDS)) ? S_OVER : S_SHOW;
            end
            default: state_d = S_IDLE;
        endcase

        game_d = (state_d == S_SHOW) || (state_d == S_WAIT) || (state_d == S_JUDGE);
        done_d = (state_d == S_OVER);
    end

    always_ff @(posedge board_clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q       <= S_IDLE;
            lfsr_q        <= SEED;
            pattern_q     <= '0;
            count_q       <= '0;
            score_q       <= '0;
            roundres_q    <= 1'b0;
            round_valid_q <= 1'b0;
            done_q        <= 1'b0;
            game_q        <= 1'b0;
            hit_q         <= 1'b0;
            win_q         <= '0;
            sw_meta_q     <= '0;
            sw_s_q        <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            pattern_q     <= pattern_d;
            count_q       <= count_d;
            score_q       <= score_d;
            roundres_q    <= roundres_d;
            round_valid_q <= round_valid_d;
            done_q        <= done_d;
            game_q        <= game_d;
            hit_q         <= hit_d;
            win_q         <= win_d;
            sw_meta_q     <= sw_meta_d;
            sw_s_q        <= sw_s_d;
        end
    end

    assign pattern     = pattern_q;
    assign game        = game_q;
    assign count       = count_q;
    assign score       = score_q;
    assign roundres    = roundres_q;
    assign round_valid = round_valid_q;
    assign done        = done_q;

endmodule
